// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 geometry, FSM encoding and pixel types
// for the VGA sync decoder.
package vga_pkg;

    localparam int H_TOTAL  = 800;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL  = 525;
    localparam int V_ACTIVE = 480;

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic [31:0] rgb_sum(input rgb_t p);
        return {24'd0, p.r} + {24'd0, p.g} + {24'd0, p.b};
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: normalises a sync input to active-high and
// flags the first cycle of each assertion.
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic rise
);

    logic level;
    logic prev;

    assign level = sync_in ^ ACTIVE_LOW;
    assign rise  = level & ~prev;

    // Reset to "asserted" so a sync held active through reset is no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, line/frame geometry,
// lock status and a per-frame checksum from an HS/VS/RGB stream.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter bit HS_ACTIVE_LOW = 1'b1,
    parameter bit VS_ACTIVE_LOW = 1'b1,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank_n,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        pixel_valid,
    output logic [9:0]  column,
    output logic [9:0]  row,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        frame_start,
    output logic [11:0] line_len,
    output logic [10:0] h_active,
    output logic [10:0] v_total,
    output logic [10:0] v_active,
    output logic [31:0] frame_sum,
    output logic        locked,
    output logic        sync_error
);

    logic        s1_hs;
    logic        s1_vs;
    logic        s1_blank_n;
    rgb_t        s1_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hs      <= HS_ACTIVE_LOW;
            s1_vs      <= VS_ACTIVE_LOW;
            s1_blank_n <= 1'b0;
            s1_pix     <= '0;
        end else begin
            s1_hs      <= hs;
            s1_vs      <= vs;
            s1_blank_n <= blank_n;
            s1_pix     <= '{r: r, g: g, b: b};
        end
    end

    logic hs_rise;
    logic vs_rise;

    sync_edge_detect #(.ACTIVE_LOW(HS_ACTIVE_LOW)) u_hs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_in (s1_hs),
        .rise    (hs_rise)
    );

    sync_edge_detect #(.ACTIVE_LOW(VS_ACTIVE_LOW)) u_vs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_in (s1_vs),
        .rise    (vs_rise)
    );

    logic [11:0] h_cnt;
    logic [10:0] act_cnt;
    logic [10:0] v_cnt;
    logic [10:0] row_cnt;
    logic [31:0] sum_acc;
    logic        seen_vs;
    logic        seen_hs;
    logic [11:0] line_len_q;
    logic [10:0] h_active_q;
    logic [10:0] v_total_q;
    logic [10:0] v_active_q;
    logic [31:0] frame_sum_q;

    logic [10:0] cur_act;
    logic [10:0] cur_row;
    logic        line_act;
    logic        row_inc;
    logic        h_sat;
    logic [31:0] pix_add;
    logic [11:0] meas_len;

    assign line_act = act_cnt != 11'd0;
    assign row_inc  = hs_rise && line_act;
    assign cur_act  = hs_rise ? 11'd0 : act_cnt;
    assign cur_row  = vs_rise ? 11'd0 :
                      row_inc ? row_cnt + 11'd1 : row_cnt;
    assign h_sat    = h_cnt == 12'hFFF;
    assign pix_add  = s1_blank_n ? rgb_sum(s1_pix) : 32'd0;
    assign meas_len = hs_rise ? h_cnt : line_len_q;

    // Measurements latch only once a full line/frame has been seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            act_cnt     <= '0;
            v_cnt       <= '0;
            row_cnt     <= '0;
            sum_acc     <= '0;
            seen_vs     <= 1'b0;
            seen_hs     <= 1'b0;
            line_len_q  <= '0;
            h_active_q  <= '0;
            v_total_q   <= '0;
            v_active_q  <= '0;
            frame_sum_q <= '0;
        end else begin
            act_cnt <= cur_act + {10'd0, s1_blank_n};
            row_cnt <= cur_row;
            if (hs_rise) begin
                h_cnt   <= 12'd1;
                seen_hs <= 1'b1;
                if (seen_hs && seen_vs) begin
                    line_len_q <= h_cnt;
                    if (line_act) begin
                        h_active_q <= act_cnt;
                    end
                end
            end else if (!h_sat) begin
                h_cnt <= h_cnt + 12'd1;
            end
            if (vs_rise) begin
                v_cnt   <= hs_rise ? 11'd1 : 11'd0;
                seen_vs <= 1'b1;
                sum_acc <= pix_add;
                if (seen_vs) begin
                    v_total_q   <= v_cnt;
                    v_active_q  <= row_cnt + {10'd0, row_inc};
                    frame_sum_q <= sum_acc;
                end
            end else begin
                sum_acc <= sum_acc + pix_add;
                if (hs_rise && v_cnt != 11'h7FF) begin
                    v_cnt <= v_cnt + 11'd1;
                end
            end
        end
    end

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [3:0]  match_cnt;
    logic [3:0]  match_n;
    logic [11:0] ref_len;
    logic [11:0] ref_len_n;
    logic [10:0] ref_vtot;
    logic [10:0] ref_vtot_n;
    logic        ref_valid;
    logic        ref_valid_n;
    logic        err;
    logic        err_q;
    logic        ref_hit;

    assign ref_hit = ref_valid && meas_len == ref_len &&
                     v_cnt == ref_vtot;

    // The frame that set the reference counts as the first stable frame
    always_comb begin
        state_n     = state;
        match_n     = match_cnt;
        ref_len_n   = ref_len;
        ref_vtot_n  = ref_vtot;
        ref_valid_n = ref_valid;
        err         = 1'b0;
        if (h_sat) begin
            err         = state == LOCKED;
            state_n     = SEARCH;
            match_n     = '0;
            ref_valid_n = 1'b0;
        end else begin
            unique case (1'b1)
                state == SEARCH: begin
                    if (vs_rise) begin
                        state_n     = TRACK;
                        match_n     = '0;
                        ref_valid_n = 1'b0;
                    end
                end
                state == TRACK: begin
                    if (vs_rise && ref_hit) begin
                        match_n = match_cnt + 4'd1;
                        if (int'(match_cnt) + 2 >= LOCK_FRAMES) begin
                            state_n = LOCKED;
                        end
                    end else if (vs_rise) begin
                        ref_len_n   = meas_len;
                        ref_vtot_n  = v_cnt;
                        ref_valid_n = 1'b1;
                        match_n     = '0;
                    end
                end
                state == LOCKED: begin
                    if ((hs_rise && h_cnt != ref_len) ||
                        (vs_rise && v_cnt != ref_vtot)) begin
                        err     = 1'b1;
                        state_n = TRACK;
                        match_n = '0;
                    end
                end
                default: begin
                    state_n = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            match_cnt <= '0;
            ref_len   <= '0;
            ref_vtot  <= '0;
            ref_valid <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            match_cnt <= match_n;
            ref_len   <= ref_len_n;
            ref_vtot  <= ref_vtot_n;
            ref_valid <= ref_valid_n;
            err_q     <= err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_valid <= 1'b0;
            column      <= '0;
            row         <= '0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            frame_start <= 1'b0;
            line_len    <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            frame_sum   <= '0;
            locked      <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            pixel_valid <= s1_blank_n && (seen_vs || vs_rise);
            column      <= cur_act[9:0];
            row         <= cur_row[9:0];
            pix_r       <= s1_pix.r;
            pix_g       <= s1_pix.g;
            pix_b       <= s1_pix.b;
            frame_start <= vs_rise;
            line_len    <= line_len_q;
            h_active    <= h_active_q;
            v_total     <= v_total_q;
            v_active    <= v_active_q;
            frame_sum   <= frame_sum_q;
            locked      <= state == LOCKED;
            sync_error  <= err_q;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scaled-geometry stream generator with a pixel
// scoreboard and per-scenario measurement checks.
module tb_vga_sync_decoder;

    localparam int HA   = 64;
    localparam int HFP  = 4;
    localparam int HSW  = 8;
    localparam int HT   = 80;
    localparam int VA   = 12;
    localparam int VFP  = 1;
    localparam int VSW  = 2;
    localparam int VT   = 16;
    localparam int HS_X = HA + HFP;
    localparam int VS_Y = VA + VFP;
    localparam int NONE = 1 << 30;

    logic        clk;
    logic        rst_n;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        pixel_valid;
    logic [9:0]  column;
    logic [9:0]  row;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        frame_start;
    logic [11:0] line_len;
    logic [10:0] h_active;
    logic [10:0] v_total;
    logic [10:0] v_active;
    logic [31:0] frame_sum;
    logic        locked;
    logic        sync_error;

    vga_sync_decoder #(
        .HS_ACTIVE_LOW (1'b1),
        .VS_ACTIVE_LOW (1'b1),
        .LOCK_FRAMES   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hs          (hs),
        .vs          (vs),
        .blank_n     (blank_n),
        .r           (r),
        .g           (g),
        .b           (b),
        .pixel_valid (pixel_valid),
        .column      (column),
        .row         (row),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .frame_start (frame_start),
        .line_len    (line_len),
        .h_active    (h_active),
        .v_total     (v_total),
        .v_active    (v_active),
        .frame_sum   (frame_sum),
        .locked      (locked),
        .sync_error  (sync_error)
    );

    int          checks  = 0;
    int          errors  = 0;
    int          fs_cnt  = 0;
    int          se_cnt  = 0;
    int          pop_cnt = 0;
    logic [43:0] sb[$];
    logic        vs_lvl     = 1'b0;
    bit          model_seen = 1'b0;
    logic [31:0] sum_acc    = 32'd0;
    logic [31:0] exp_sum    = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        logic [43:0] got;
        logic [43:0] exp;
        if (frame_start) fs_cnt++;
        if (sync_error) se_cnt++;
        if (pixel_valid) begin
            got = {column, row, pix_r, pix_g, pix_b};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pixel_extra: got %h expected none", got);
            end else begin
                exp = sb.pop_front();
                pop_cnt++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL pixel: got %h expected %h", got, exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        hs      = 1'b1;
        vs      = ~vs_lvl;
        blank_n = 1'b0;
        r       = 8'd0;
        g       = 8'd0;
        b       = 8'd0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst_n      = 1'b0;
        vs_lvl     = 1'b0;
        model_seen = 1'b0;
        sum_acc    = 32'd0;
        exp_sum    = 32'd0;
        sb.delete();
        idle(3);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic drain;
        idle(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
    endtask

    task automatic drive_frames(input int nfr, input int long_from,
                                input int coinc, input int pat,
                                input int rst_line);
        int gl;
        gl = 0;
        for (int f = 0; f < nfr; f++) begin
            for (int y = 0; y < VT; y++) begin
                int ht;
                ht = (gl >= long_from) ? HT + 1 : HT;
                for (int x = 0; x < ht; x++) begin
                    logic       act;
                    logic [7:0] cr;
                    logic [7:0] cg;
                    logic [7:0] cb;
                    int         vx;
                    if (gl == rst_line && x == 20) begin
                        rst_n      = 1'b0;
                        model_seen = 1'b0;
                        sum_acc    = 32'd0;
                        sb.delete();
                        #1;
                        checks++;
                        if ({pixel_valid, column, row, pix_r, pix_g,
                             pix_b, frame_start, line_len, h_active,
                             v_total, v_active, frame_sum, locked,
                             sync_error} !== '0) begin
                            errors++;
                            $display("FAIL reset_mid: got nonzero %0d %0d %0d expected 0",
                                     line_len, v_total, locked);
                        end
                        @(negedge clk);
                        rst_n = 1'b1;
                    end
                    vx = coinc ? HS_X : HS_X - 1;
                    if (y == VS_Y && x == vx) begin
                        vs_lvl = 1'b1;
                        if (model_seen) exp_sum = sum_acc;
                        sum_acc    = 32'd0;
                        model_seen = 1'b1;
                    end
                    if (y == VS_Y + VSW && x == vx) vs_lvl = 1'b0;
                    act = x < HA && y < VA;
                    cr  = 8'd0;
                    cg  = 8'd0;
                    cb  = 8'd0;
                    if (pat == 0) begin
                        cr = 8'hff;
                    end else if (pat == 1) begin
                        if (x < HA / 4 || x >= 3 * HA / 4) cr = 8'hff;
                        else if (x < HA / 2) cb = 8'hff;
                        else cg = 8'hff;
                    end else begin
                        cr = 8'(x * 3);
                        cg = 8'(y * 7 + 1);
                        cb = 8'(x + y);
                    end
                    hs      = ~(x >= HS_X && x < HS_X + HSW);
                    vs      = ~vs_lvl;
                    blank_n = act;
                    r       = act ? cr : 8'd0;
                    g       = act ? cg : 8'd0;
                    b       = act ? cb : 8'd0;
                    if (act && model_seen) begin
                        sb.push_back({10'(x), 10'(y), cr, cg, cb});
                        sum_acc = sum_acc + {24'd0, cr} +
                                  {24'd0, cg} + {24'd0, cb};
                    end
                    @(posedge clk);
                    #1;
                end
                gl++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        checks++;
        if ({pixel_valid, column, row, frame_start, line_len,
             v_total, frame_sum, locked, sync_error} !== '0) begin
            errors++;
            $display("FAIL reset_state: got nonzero %0d %0d expected 0",
                     line_len, locked);
        end
    endtask

    task automatic test_standard;
        int fs0;
        int se0;
        do_reset();
        fs0 = fs_cnt;
        se0 = se_cnt;
        drive_frames(2, NONE, 0, 0, NONE);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: got %b expected 0", locked);
        end
        drive_frames(1, NONE, 0, 0, NONE);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_3vs: got %b expected 1", locked);
        end
        checks++;
        if (line_len !== 12'd80) begin
            errors++;
            $display("FAIL line_len: got %0d expected 80", line_len);
        end
        checks++;
        if (h_active !== 11'd64) begin
            errors++;
            $display("FAIL h_active: got %0d expected 64", h_active);
        end
        checks++;
        if (v_total !== 11'd16) begin
            errors++;
            $display("FAIL v_total: got %0d expected 16", v_total);
        end
        checks++;
        if (v_active !== 11'd12) begin
            errors++;
            $display("FAIL v_active: got %0d expected 12", v_active);
        end
        checks++;
        if (frame_sum !== 32'd195840) begin
            errors++;
            $display("FAIL frame_sum_red: got %0d expected 195840",
                     frame_sum);
        end
        checks++;
        if (fs_cnt - fs0 != 3) begin
            errors++;
            $display("FAIL frame_start_cnt: got %0d expected 3",
                     fs_cnt - fs0);
        end
        checks++;
        if (se_cnt != se0) begin
            errors++;
            $display("FAIL sync_error_idle: got %0d expected 0",
                     se_cnt - se0);
        end
        drain();
    endtask

    task automatic test_bands;
        int p0;
        do_reset();
        p0 = pop_cnt;
        drive_frames(2, NONE, 0, 1, NONE);
        drain();
        checks++;
        if (pop_cnt - p0 != HA * VA) begin
            errors++;
            $display("FAIL band_pixels: got %0d expected %0d",
                     pop_cnt - p0, HA * VA);
        end
        checks++;
        if (frame_sum !== exp_sum) begin
            errors++;
            $display("FAIL band_sum: got %0d expected %0d",
                     frame_sum, exp_sum);
        end
    endtask

    task automatic test_ramp_sum;
        do_reset();
        drive_frames(3, NONE, 0, 2, NONE);
        checks++;
        if (frame_sum !== exp_sum) begin
            errors++;
            $display("FAIL ramp_sum: got %0d expected %0d",
                     frame_sum, exp_sum);
        end
        drain();
    endtask

    task automatic test_long_line;
        int se0;
        do_reset();
        drive_frames(3, NONE, 0, 0, NONE);
        se0 = se_cnt;
        drive_frames(1, 5, 0, 0, NONE);
        checks++;
        if (se_cnt - se0 != 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL long_err: got %0d pulses locked %b expected 1 0",
                     se_cnt - se0, locked);
        end
        drive_frames(1, 0, 0, 0, NONE);
        checks++;
        if (locked !== 1'b1 || line_len !== 12'd81) begin
            errors++;
            $display("FAIL long_relock: got %b %0d expected 1 81",
                     locked, line_len);
        end
        checks++;
        if (se_cnt - se0 != 1) begin
            errors++;
            $display("FAIL long_err_once: got %0d expected 1",
                     se_cnt - se0);
        end
        drain();
    endtask

    task automatic test_timeout;
        int se0;
        do_reset();
        drive_frames(3, NONE, 0, 0, NONE);
        se0 = se_cnt;
        idle(4200);
        checks++;
        if (se_cnt - se0 != 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout: got %0d pulses locked %b expected 1 0",
                     se_cnt - se0, locked);
        end
        drive_frames(3, NONE, 0, 0, NONE);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL timeout_relock: got %b expected 1", locked);
        end
        drain();
    endtask

    task automatic test_reset_mid;
        int fs0;
        do_reset();
        fs0 = fs_cnt;
        drive_frames(2, NONE, 0, 0, VT + 3);
        checks++;
        if (fs_cnt - fs0 != 2) begin
            errors++;
            $display("FAIL reset_fs: got %0d expected 2", fs_cnt - fs0);
        end
        checks++;
        if (v_total !== 11'd0) begin
            errors++;
            $display("FAIL reset_vtot_partial: got %0d expected 0",
                     v_total);
        end
        drive_frames(1, NONE, 0, 0, NONE);
        checks++;
        if (v_total !== 11'd16 || frame_sum !== exp_sum) begin
            errors++;
            $display("FAIL reset_vtot: got %0d %0d expected 16 %0d",
                     v_total, frame_sum, exp_sum);
        end
        drain();
    endtask

    task automatic test_coincident;
        for (int c = 0; c < 2; c++) begin
            do_reset();
            drive_frames(3, NONE, c, 0, NONE);
            checks++;
            if (v_total !== 11'd16 || locked !== 1'b1) begin
                errors++;
                $display("FAIL coinc%0d: got %0d %b expected 16 1",
                         c, v_total, locked);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_standard();
        test_bands();
        test_ramp_sum();
        test_long_line();
        test_timeout();
        test_reset_mid();
        test_coincident();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
